// File: rtl/rx_status_regmap.sv
// AXI-lite register map for the receiver: identity words, read-only status words,
// strobed control registers and a sticky event block with enable-gated interrupt.
module rx_status_regmap #(
   parameter logic [31:0]          ID            = 32'h0000_0000,
   parameter int                   ADDRESS_WIDTH = 11,
   parameter int                   N_STATUS      = 8,
   parameter int                   N_CTRL        = 4,
   parameter int                   N_EVENTS      = 8,
   parameter logic [N_CTRL*32-1:0] CTRL_RESET    = '0
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [ADDRESS_WIDTH-1:0] s_axi_if_awaddr,
   input  logic                     s_axi_if_awvalid,
   output logic                     s_axi_if_awready,
   input  logic [31:0]              s_axi_if_wdata,
   input  logic [3:0]               s_axi_if_wstrb,
   input  logic                     s_axi_if_wvalid,
   output logic                     s_axi_if_wready,
   output logic [1:0]               s_axi_if_bresp,
   output logic                     s_axi_if_bvalid,
   input  logic                     s_axi_if_bready,
   input  logic [ADDRESS_WIDTH-1:0] s_axi_if_araddr,
   input  logic                     s_axi_if_arvalid,
   output logic                     s_axi_if_arready,
   output logic [31:0]              s_axi_if_rdata,
   output logic [1:0]               s_axi_if_rresp,
   output logic                     s_axi_if_rvalid,
   input  logic                     s_axi_if_rready,
   input  logic [N_STATUS*32-1:0]   status_i,
   output logic [N_CTRL*32-1:0]     ctrl_o,
   output logic [N_CTRL-1:0]        ctrl_wr_o,
   input  logic [N_EVENTS-1:0]      event_i,
   output logic                     irq_o
);

   localparam int          AW       = ADDRESS_WIDTH - 2;
   localparam logic [31:0] VERSION  = 32'h0005_0000;
   localparam logic [31:0] MAGIC    = 32'h5258_7E7E;
   localparam logic [31:0] GEOMETRY = 32'(N_STATUS) | (32'(N_CTRL) << 8) | (32'(N_EVENTS) << 16);
   localparam logic [31:0] EVT_MASK = 32'((64'd1 << N_EVENTS) - 64'd1);

   typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   function automatic logic [31:0] f_merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                           input logic [3:0] strb);
      logic [31:0] m;
      m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_val & ~m) | (new_val & m);
   endfunction

   w_state_t            r_wstate, w_wstate_next;
   r_state_t            r_rstate, w_rstate_next;
   logic                r_rdy_en;
   logic                r_aw_held, r_w_held;
   logic [AW-1:0]       r_awaddr;
   logic [31:0]         r_wdata;
   logic [3:0]          r_wstrb;
   logic [1:0]          r_bresp;
   logic [31:0]         r_rdata;
   logic [1:0]          r_rresp;
   logic [31:0]         r_scratch, r_evt_en, r_evt_status;
   logic [N_CTRL*32-1:0] r_ctrl;
   logic [N_CTRL-1:0]   r_ctrl_wr;
   logic                r_irq;

   logic                w_aw_hs, w_w_hs, w_ar_hs, w_exec;
   logic [AW-1:0]       w_wr_word, w_ar_word;
   logic                w_wr_ctrl, w_wr_ok;
   logic [31:0]         w_w1c, w_evt_in, w_rd_data;
   logic                w_rd_err;
   logic [31:0]         w_status_arr [16];
   logic [31:0]         w_ctrl_arr [16];
   logic                w_unused;

   // Byte-lane bits of the addresses carry no meaning in a word-only map.
   assign w_unused = &{1'b0, s_axi_if_awaddr[1:0], s_axi_if_araddr[1:0]};

   assign s_axi_if_awready = r_rdy_en && (r_wstate == W_IDLE) && !r_aw_held;
   assign s_axi_if_wready  = r_rdy_en && (r_wstate == W_IDLE) && !r_w_held;
   assign s_axi_if_arready = r_rdy_en && (r_rstate == R_IDLE);
   assign s_axi_if_bvalid  = (r_wstate == W_RESP);
   assign s_axi_if_rvalid  = (r_rstate == R_DATA);
   assign s_axi_if_bresp   = r_bresp;
   assign s_axi_if_rdata   = r_rdata;
   assign s_axi_if_rresp   = r_rresp;
   assign ctrl_o           = r_ctrl;
   assign ctrl_wr_o        = r_ctrl_wr;
   assign irq_o            = r_irq;

   assign w_aw_hs   = s_axi_if_awvalid && s_axi_if_awready;
   assign w_w_hs    = s_axi_if_wvalid && s_axi_if_wready;
   assign w_ar_hs   = s_axi_if_arvalid && s_axi_if_arready;
   assign w_exec    = (r_wstate == W_EXEC);
   assign w_wr_word = r_awaddr;
   assign w_ar_word = s_axi_if_araddr[ADDRESS_WIDTH-1:2];
   assign w_evt_in  = 32'(event_i);
   assign w_wr_ctrl = (w_wr_word >= AW'(32)) && (w_wr_word < AW'(32 + N_CTRL));
   assign w_wr_ok   = w_wr_ctrl || (w_wr_word == AW'(4)) || (w_wr_word == AW'(5)) ||
                      (w_wr_word == AW'(6));
   assign w_w1c     = (w_exec && w_wr_word == AW'(5)) ? f_merge(32'h0, r_wdata, r_wstrb) : 32'h0;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_words
         if (gi < N_STATUS) begin : g_st
            assign w_status_arr[gi] = status_i[32*gi +: 32];
         end else begin : g_st_none
            assign w_status_arr[gi] = 32'h0;
         end
         if (gi < N_CTRL) begin : g_ct
            assign w_ctrl_arr[gi] = r_ctrl[32*gi +: 32];
         end else begin : g_ct_none
            assign w_ctrl_arr[gi] = 32'h0;
         end
      end
   endgenerate

   always_comb begin
      w_wstate_next = r_wstate;
      case (r_wstate)
         W_IDLE:  if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) w_wstate_next = W_EXEC;
         W_EXEC:  w_wstate_next = W_RESP;
         W_RESP:  if (s_axi_if_bready) w_wstate_next = W_IDLE;
         default: w_wstate_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wstate  <= W_IDLE;
         r_rdy_en  <= 1'b0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= 2'b00;
      end else begin
         r_wstate <= w_wstate_next;
         r_rdy_en <= 1'b1;
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= s_axi_if_awaddr[ADDRESS_WIDTH-1:2];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi_if_wdata;
            r_wstrb  <= s_axi_if_wstrb;
         end
         if (w_exec) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
         end
      end
   end

   // Register file; an event arriving in the clearing cycle survives the W1C.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_scratch    <= '0;
         r_evt_en     <= '0;
         r_evt_status <= '0;
         r_ctrl       <= CTRL_RESET;
         r_ctrl_wr    <= '0;
         r_irq        <= 1'b0;
      end else begin
         r_ctrl_wr    <= '0;
         r_evt_status <= ((r_evt_status & ~w_w1c) | w_evt_in) & EVT_MASK;
         r_irq        <= |(r_evt_status & r_evt_en);
         if (w_exec) begin
            if (w_wr_word == AW'(4)) r_scratch <= f_merge(r_scratch, r_wdata, r_wstrb);
            if (w_wr_word == AW'(6)) r_evt_en <= f_merge(r_evt_en, r_wdata, r_wstrb) & EVT_MASK;
            for (int j = 0; j < N_CTRL; j++) begin
               if (w_wr_word == AW'(32 + j)) begin
                  r_ctrl[32*j +: 32] <= f_merge(r_ctrl[32*j +: 32], r_wdata, r_wstrb);
                  r_ctrl_wr[j]       <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      w_rd_data = 32'h0;
      w_rd_err  = 1'b0;
      if (w_ar_word >= AW'(16) && w_ar_word < AW'(16 + N_STATUS)) begin
         w_rd_data = w_status_arr[w_ar_word[3:0]];
      end else if (w_ar_word >= AW'(32) && w_ar_word < AW'(32 + N_CTRL)) begin
         w_rd_data = w_ctrl_arr[w_ar_word[3:0]];
      end else begin
         case (w_ar_word)
            AW'(0):  w_rd_data = VERSION;
            AW'(1):  w_rd_data = ID;
            AW'(2):  w_rd_data = GEOMETRY;
            AW'(3):  w_rd_data = MAGIC;
            AW'(4):  w_rd_data = r_scratch;
            AW'(5):  w_rd_data = r_evt_status;
            AW'(6):  w_rd_data = r_evt_en;
            default: w_rd_err  = 1'b1;
         endcase
      end
   end

   always_comb begin
      w_rstate_next = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
         R_DATA:  if (s_axi_if_rready) w_rstate_next = R_IDLE;
         default: w_rstate_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_rstate <= R_IDLE;
         r_rdata  <= '0;
         r_rresp  <= 2'b00;
      end else begin
         r_rstate <= w_rstate_next;
         if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_err ? 2'b10 : 2'b00;
         end
      end
   end

endmodule

// File: tb/tb_rx_status_regmap.sv
// Scoreboard bench for rx_status_regmap: AXI-lite reads/writes, strobes, error
// responses, sticky events with interrupt, and reset in the middle of a write.
module tb_rx_status_regmap;

   localparam logic [31:0]  TB_ID    = 32'hCAFE_0001;
   localparam logic [127:0] CTRL_RST = {32'h0000_0004, 32'h0000_0003, 32'h1122_3344, 32'h0000_0001};

   logic         clk = 1'b0;
   logic         reset_i;
   logic [10:0]  awaddr, araddr;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [255:0] status_i;
   logic [127:0] ctrl_o;
   logic [3:0]   ctrl_wr, pulse;
   logic [7:0]   event_i;
   logic         irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q_exp_rdata[$];
   logic [1:0]  q_exp_rresp[$];
   logic [1:0]  q_exp_bresp[$];

   always #5 clk = ~clk;

   rx_status_regmap #(
      .ID(TB_ID), .ADDRESS_WIDTH(11), .N_STATUS(8), .N_CTRL(4), .N_EVENTS(8), .CTRL_RESET(CTRL_RST)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .s_axi_if_awaddr(awaddr), .s_axi_if_awvalid(awvalid), .s_axi_if_awready(awready),
      .s_axi_if_wdata(wdata), .s_axi_if_wstrb(wstrb), .s_axi_if_wvalid(wvalid), .s_axi_if_wready(wready),
      .s_axi_if_bresp(bresp), .s_axi_if_bvalid(bvalid), .s_axi_if_bready(bready),
      .s_axi_if_araddr(araddr), .s_axi_if_arvalid(arvalid), .s_axi_if_arready(arready),
      .s_axi_if_rdata(rdata), .s_axi_if_rresp(rresp), .s_axi_if_rvalid(rvalid), .s_axi_if_rready(rready),
      .status_i(status_i), .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr), .event_i(event_i), .irq_o(irq)
   );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_read(input logic [10:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int hold);
      int          t;
      logic [31:0] d0;
      q_exp_rdata.push_back(exp_data);
      q_exp_rresp.push_back(exp_resp);
      araddr  = addr;
      arvalid = 1'b1;
      t = 0;
      while (!arready && t < 20) begin
         tick();
         t++;
      end
      check_eq("ar_timeout", 128'(t >= 20), 128'(0));
      tick();
      arvalid = 1'b0;
      check_eq("rvalid_lat", 128'(rvalid), 128'(1));
      d0 = rdata;
      for (int i = 0; i < hold; i++) begin
         status_i = ~status_i;
         tick();
         check_eq("rvalid_hold", 128'(rvalid), 128'(1));
         check_eq("rdata_hold", 128'(rdata), 128'(d0));
      end
      rready = 1'b1;
      check_eq($sformatf("rdata@%h", addr), 128'(rdata), 128'(q_exp_rdata.pop_front()));
      check_eq($sformatf("rresp@%h", addr), 128'(rresp), 128'(q_exp_rresp.pop_front()));
      $display("RD addr=%h data=%h resp=%0d", addr, rdata, rresp);
      tick();
      rready = 1'b0;
      check_eq("rvalid_drop", 128'(rvalid), 128'(0));
   endtask

   task automatic axi_write(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input int w_lead, input logic [7:0] ev_exec,
                            output logic [3:0] wr_pulse);
      int   t;
      logic aw_done, w_done, aw_acc, w_acc;
      q_exp_bresp.push_back(exp_resp);
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      wvalid  = 1'b1;
      awvalid = (w_lead == 0);
      aw_done = 1'b0;
      w_done  = 1'b0;
      t = 0;
      while (!(aw_done && w_done) && t < 40) begin
         aw_acc = awvalid && awready;
         w_acc  = wvalid && wready;
         tick();
         t++;
         if (aw_acc) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_acc)  begin wvalid  = 1'b0; w_done  = 1'b1; end
         if (!aw_done && t >= w_lead) awvalid = 1'b1;
      end
      check_eq("aw_w_timeout", 128'(t >= 40), 128'(0));
      event_i = ev_exec;
      check_eq("bvalid_early", 128'(bvalid), 128'(0));
      tick();
      event_i = 8'h00;
      check_eq("bvalid_lat", 128'(bvalid), 128'(1));
      wr_pulse = ctrl_wr;
      bready   = 1'b1;
      check_eq($sformatf("bresp@%h", addr), 128'(bresp), 128'(q_exp_bresp.pop_front()));
      $display("WR addr=%h data=%h strb=%b resp=%0d", addr, data, strb, bresp);
      tick();
      bready = 1'b0;
      check_eq("bvalid_drop", 128'(bvalid), 128'(0));
      check_eq("ctrl_wr_single", 128'(ctrl_wr), 128'(0));
   endtask

   initial begin
      reset_i = 1'b1;
      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
      araddr = '0; arvalid = 0; rready = 0; event_i = '0;
      for (int i = 0; i < 8; i++) status_i[32*i +: 32] = 32'h0101_0101 * i;
      status_i[32*5 +: 32] = 32'hDEAD_BEEF;
      repeat (3) tick();
      check_eq("rst_awready", 128'(awready), 128'(0));
      check_eq("rst_wready", 128'(wready), 128'(0));
      check_eq("rst_arready", 128'(arready), 128'(0));
      check_eq("rst_bvalid", 128'(bvalid), 128'(0));
      check_eq("rst_rvalid", 128'(rvalid), 128'(0));
      check_eq("rst_irq", 128'(irq), 128'(0));
      check_eq("rst_ctrl", ctrl_o, CTRL_RST);
      reset_i = 1'b0;
      tick();
      check_eq("awready_up", 128'(awready), 128'(1));
      check_eq("arready_up", 128'(arready), 128'(1));

      axi_read(11'h000, 32'h0005_0000, 2'b00, 0);
      axi_read(11'h004, TB_ID, 2'b00, 0);
      axi_read(11'h008, 32'h0008_0408, 2'b00, 0);
      axi_read(11'h00C, 32'h5258_7E7E, 2'b00, 0);
      axi_read(11'h084, 32'h1122_3344, 2'b00, 0);

      axi_write(11'h084, 32'hA5A5_A5A5, 4'b0011, 2'b00, 0, 8'h00, pulse);
      check_eq("ctrl_wr_pulse", 128'(pulse), 128'(4'b0010));
      check_eq("ctrl1_strb", 128'(ctrl_o[63:32]), 128'(32'h1122_A5A5));
      axi_write(11'h084, 32'h1122_3344, 4'b1111, 2'b00, 0, 8'h00, pulse);
      check_eq("ctrl1_restore", 128'(ctrl_o[63:32]), 128'(32'h1122_3344));
      axi_write(11'h084, 32'hA5A5_A5A5, 4'b0011, 2'b00, 3, 8'h00, pulse);
      check_eq("ctrl_wr_pulse_wlead", 128'(pulse), 128'(4'b0010));
      check_eq("ctrl1_wlead", 128'(ctrl_o[63:32]), 128'(32'h1122_A5A5));
      axi_read(11'h084, 32'h1122_A5A5, 2'b00, 0);

      axi_write(11'h010, 32'hDEAD_BEEF, 4'b1111, 2'b00, 0, 8'h00, pulse);
      axi_write(11'h010, 32'h0000_0055, 4'b0001, 2'b00, 0, 8'h00, pulse);
      check_eq("scratch_no_pulse", 128'(pulse), 128'(0));
      axi_read(11'h010, 32'hDEAD_BE55, 2'b00, 0);

      axi_write(11'h040, 32'hFFFF_FFFF, 4'b1111, 2'b10, 0, 8'h00, pulse);
      check_eq("ro_no_pulse", 128'(pulse), 128'(0));
      axi_write(11'h1FC, 32'hFFFF_FFFF, 4'b1111, 2'b10, 0, 8'h00, pulse);
      check_eq("unmapped_no_pulse", 128'(pulse), 128'(0));
      axi_write(11'h000, 32'h1234_5678, 4'b1111, 2'b10, 0, 8'h00, pulse);
      check_eq("ctrl_untouched", ctrl_o, {CTRL_RST[127:64], 32'h1122_A5A5, CTRL_RST[31:0]});
      axi_read(11'h1FC, 32'h0000_0000, 2'b10, 0);
      axi_read(11'h000, 32'h0005_0000, 2'b00, 0);

      axi_write(11'h018, 32'hFFFF_FFFF, 4'b1111, 2'b00, 0, 8'h00, pulse);
      axi_read(11'h018, 32'h0000_00FF, 2'b00, 0);
      axi_write(11'h018, 32'h0000_0008, 4'b1111, 2'b00, 0, 8'h00, pulse);
      event_i = 8'h08;
      tick();
      event_i = 8'h00;
      check_eq("irq_n1", 128'(irq), 128'(0));
      tick();
      check_eq("irq_n2", 128'(irq), 128'(1));
      $display("EVT bit3 pulse irq=%0d", irq);
      axi_read(11'h014, 32'h0000_0008, 2'b00, 0);

      axi_write(11'h014, 32'h0000_0008, 4'b1111, 2'b00, 0, 8'h08, pulse);
      axi_read(11'h014, 32'h0000_0008, 2'b00, 0);
      check_eq("irq_set_wins", 128'(irq), 128'(1));
      axi_write(11'h014, 32'h0000_0008, 4'b1111, 2'b00, 0, 8'h00, pulse);
      check_eq("irq_cleared", 128'(irq), 128'(0));
      axi_read(11'h014, 32'h0000_0000, 2'b00, 0);

      axi_read(11'h054, 32'hDEAD_BEEF, 2'b00, 4);

      check_eq("pre_rst_awready", 128'(awready), 128'(1));
      awaddr = 11'h088; wdata = 32'hFFFF_FFFF; wstrb = 4'b1111;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      check_eq("mid_bvalid", 128'(bvalid), 128'(1));
      check_eq("mid_ctrl2", 128'(ctrl_o[95:64]), 128'(32'hFFFF_FFFF));
      reset_i = 1'b1;
      tick();
      check_eq("rst_mid_bvalid", 128'(bvalid), 128'(0));
      check_eq("rst_mid_ctrl", ctrl_o, CTRL_RST);
      check_eq("rst_mid_awready", 128'(awready), 128'(0));
      reset_i = 1'b0;
      tick();
      check_eq("post_rst_awready", 128'(awready), 128'(1));
      check_eq("post_rst_bvalid", 128'(bvalid), 128'(0));
      $display("RST during write response, bvalid=%0d", bvalid);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
